// File: rtl/instr_pipe.sv
// One pipeline-stage register for an instruction word, its PC and a valid bit,
// with stall (hold) and flush (bubble). Optional parity when INSTR_PIPE_PARITY_EN is defined.
module instr_pipe #(
  parameter int unsigned         INSTR_W  = 11,
  parameter int unsigned         PC_W     = 6,
  parameter logic [INSTR_W-1:0]  NOP_WORD = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               STALL,
  input  logic               FLUSH,
  input  logic               VALID_IN,
  input  logic [INSTR_W-1:0] INSTR_IN,
  input  logic [PC_W-1:0]    COUNTER_IN,
`ifdef INSTR_PIPE_PARITY_EN
  input  logic               PARITY_IN,
  output logic               PARITY_OUT,
  output logic               PARITY_ERR,
`endif
  output logic               VALID_OUT,
  output logic [INSTR_W-1:0] INSTR_OUT,
  output logic [PC_W-1:0]    COUNTER_OUT
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_counter;

  // Flush beats stall; the PC still moves on a flush so bubbles stay traceable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_WORD;
      r_counter <= '0;
    end else if (FLUSH) begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_WORD;
      r_counter <= COUNTER_IN;
    end else if (!STALL) begin
      r_valid   <= VALID_IN;
      r_instr   <= INSTR_IN;
      r_counter <= COUNTER_IN;
    end
  end

  assign VALID_OUT   = r_valid;
  assign INSTR_OUT   = r_instr;
  assign COUNTER_OUT = r_counter;

`ifdef INSTR_PIPE_PARITY_EN
  localparam logic NOP_PAR = ^NOP_WORD;

  logic r_parity;
  logic r_parity_err;
  logic w_parity_in;

  assign w_parity_in = ^INSTR_IN;

  // Parity tracks INSTR_OUT; the error flag is checked only on valid loads.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_parity     <= NOP_PAR;
      r_parity_err <= 1'b0;
    end else if (FLUSH) begin
      r_parity     <= NOP_PAR;
      r_parity_err <= 1'b0;
    end else if (!STALL) begin
      r_parity     <= w_parity_in;
      r_parity_err <= VALID_IN & (PARITY_IN != w_parity_in);
    end
  end

  assign PARITY_OUT = r_parity;
  assign PARITY_ERR = r_parity_err;
`endif

endmodule

// File: tb/tb_instr_pipe.sv
// Scoreboard bench for a three-stage instr_pipe chain A->B->C; A takes the
// stall/flush stimulus while B and C run freely.
module tb_instr_pipe;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        vin;
  logic [10:0] instr;
  logic [5:0]  pc;
  logic        zero;

  logic        a_v, b_v, c_v;
  logic [10:0] a_i, b_i, c_i;
  logic [5:0]  a_p, b_p, c_p;

`ifdef INSTR_PIPE_PARITY_EN
  logic par_in;
  logic a_po, b_po, c_po;
  logic a_pe, b_pe, c_pe;
`endif

  typedef struct {
    int          due;
    logic        v;
    logic [10:0] i;
    logic [5:0]  p;
  } sb_t;

  sb_t qb[$];
  sb_t qc[$];
  int  cyc;
  int  n_vec;
  int  n_err;
  logic bad_par;

  instr_pipe u_a (
    .CLK(clk), .RST_N(rst_n), .STALL(stall), .FLUSH(flush),
    .VALID_IN(vin), .INSTR_IN(instr), .COUNTER_IN(pc),
`ifdef INSTR_PIPE_PARITY_EN
    .PARITY_IN(par_in), .PARITY_OUT(a_po), .PARITY_ERR(a_pe),
`endif
    .VALID_OUT(a_v), .INSTR_OUT(a_i), .COUNTER_OUT(a_p)
  );

  instr_pipe u_b (
    .CLK(clk), .RST_N(rst_n), .STALL(zero), .FLUSH(zero),
    .VALID_IN(a_v), .INSTR_IN(a_i), .COUNTER_IN(a_p),
`ifdef INSTR_PIPE_PARITY_EN
    .PARITY_IN(a_po), .PARITY_OUT(b_po), .PARITY_ERR(b_pe),
`endif
    .VALID_OUT(b_v), .INSTR_OUT(b_i), .COUNTER_OUT(b_p)
  );

  instr_pipe u_c (
    .CLK(clk), .RST_N(rst_n), .STALL(zero), .FLUSH(zero),
    .VALID_IN(b_v), .INSTR_IN(b_i), .COUNTER_IN(b_p),
`ifdef INSTR_PIPE_PARITY_EN
    .PARITY_IN(b_po), .PARITY_OUT(c_po), .PARITY_ERR(c_pe),
`endif
    .VALID_OUT(c_v), .INSTR_OUT(c_i), .COUNTER_OUT(c_p)
  );

  // 20 ns period; clk_en freezes the clock at its current level.
  always #10 if (clk_en) clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one edge, sample 1 ns later and retire any scoreboard entries due now.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      check_eq("b_valid", 32'(b_v), 32'(e.v));
      check_eq("b_instr", 32'(b_i), 32'(e.i));
      check_eq("b_pc",    32'(b_p), 32'(e.p));
    end
    while (qc.size() > 0 && qc[0].due == cyc) begin
      e = qc.pop_front();
      check_eq("c_valid", 32'(c_v), 32'(e.v));
      check_eq("c_instr", 32'(c_i), 32'(e.i));
      check_eq("c_pc",    32'(c_p), 32'(e.p));
    end
  endtask

  // Normal load into A; the same word must appear at B and C one and two edges later.
  task automatic load(input logic v, input logic [10:0] i, input logic [5:0] p);
    vin   = v;
    instr = i;
    pc    = p;
    stall = 1'b0;
    flush = 1'b0;
`ifdef INSTR_PIPE_PARITY_EN
    par_in = (^i) ^ bad_par;
`endif
    qb.push_back('{due: cyc + 2, v: v, i: i, p: p});
    qc.push_back('{due: cyc + 3, v: v, i: i, p: p});
    tick();
    check_eq("a_valid", 32'(a_v), 32'(v));
    check_eq("a_instr", 32'(a_i), 32'(i));
    check_eq("a_pc",    32'(a_p), 32'(p));
  endtask

  initial begin
    clk = 1'b0; clk_en = 1'b1; rst_n = 1'b1; zero = 1'b0;
    stall = 1'b0; flush = 1'b0; vin = 1'b1; instr = 11'h5A5; pc = 6'd17;
    bad_par = 1'b0; cyc = 0; n_vec = 0; n_err = 0;
`ifdef INSTR_PIPE_PARITY_EN
    par_in = ^instr;
`endif

    // Put live contents into the chain before resetting it
    tick();
    check_eq("warm_a_instr", 32'(a_i), 32'h5A5);
    instr = 11'h0F0; pc = 6'd3;
    tick();
    check_eq("warm_a_pc", 32'(a_p), 32'd3);

    // Asynchronous reset with the clock frozen
    clk_en = 1'b0;
    #4 rst_n = 1'b0;
    #1;
    check_eq("rst_a_instr", 32'(a_i), 32'h0);
    check_eq("rst_a_pc",    32'(a_p), 32'h0);
    check_eq("rst_a_valid", 32'(a_v), 32'h0);
    check_eq("rst_b_valid", 32'(b_v), 32'h0);
    check_eq("rst_c_instr", 32'(c_i), 32'h0);
    check_eq("rst_c_valid", 32'(c_v), 32'h0);
`ifdef INSTR_PIPE_PARITY_EN
    check_eq("rst_a_parity", 32'(a_po), 32'h0);
    check_eq("rst_a_perr",   32'(a_pe), 32'h0);
    check_eq("rst_bc_parity", 32'({b_po, b_pe, c_po, c_pe}), 32'h0);
`endif
    #5 rst_n = 1'b1;
    #3;
    check_eq("rel_a_instr", 32'(a_i), 32'h0);
    check_eq("rel_c_pc",    32'(c_p), 32'h0);
    clk_en = 1'b1;

    // Three-stage chain
    load(1'b1, 11'b11111111111, 6'd1);
    load(1'b1, 11'b00000000000, 6'd2);
    load(1'b1, 11'b11010110101, 6'd3);

    // Counter passes through untouched
    load(1'b1, 11'h123, 6'd5);
    load(1'b1, 11'h456, 6'd63);

    // Stall holds A for two edges while its inputs change
    load(1'b1, 11'b11010110101, 6'd40);
    stall = 1'b1; instr = 11'h000; pc = 6'd0; vin = 1'b1;
`ifdef INSTR_PIPE_PARITY_EN
    par_in = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("stall_a_instr", 32'(a_i), 32'b11010110101);
      check_eq("stall_a_pc",    32'(a_p), 32'd40);
      check_eq("stall_a_valid", 32'(a_v), 32'd1);
    end
    load(1'b1, 11'h000, 6'd7);

    // Flush overrides stall and still tracks the PC
    stall = 1'b1; flush = 1'b1; vin = 1'b1; instr = 11'h7FF; pc = 6'd9;
    tick();
    check_eq("flush_a_instr", 32'(a_i), 32'h0);
    check_eq("flush_a_valid", 32'(a_v), 32'h0);
    check_eq("flush_a_pc",    32'(a_p), 32'd9);
`ifdef INSTR_PIPE_PARITY_EN
    check_eq("flush_a_parity", 32'(a_po), 32'h0);
`endif

    // Data fields load even when not valid
    load(1'b0, 11'h155, 6'd33);
    load(1'b1, 11'h2AA, 6'd0);

`ifdef INSTR_PIPE_PARITY_EN
    // Seven ones with the wrong parity bit
    bad_par = 1'b1;
    load(1'b1, 11'b11010110101, 6'd12);
    check_eq("par_out", 32'(a_po), 32'd1);
    check_eq("par_err", 32'(a_pe), 32'd1);
    bad_par = 1'b0;
    load(1'b1, 11'h001, 6'd13);
    check_eq("par_out_next", 32'(a_po), 32'd1);
    check_eq("par_err_clr",  32'(a_pe), 32'd0);
    bad_par = 1'b1;
    load(1'b0, 11'h003, 6'd14);
    check_eq("par_err_invalid", 32'(a_pe), 32'd0);
    bad_par = 1'b0;
`endif

    // Drain the chain so every scoreboard entry is retired
    stall = 1'b0; flush = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_eq("qb_empty", 32'(qb.size()), 32'd0);
    check_eq("qc_empty", 32'(qc.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
